depacketizer_axis_stream: RTL
=============================

// Module: depacketizer_axis_stream
// PURPOSE
//  Receive-side framer between symbol demapper and byte sink. After preamble (PD_flag) and
//  Barker (BD_flag) detection it waits RX_BD_WINDOW symbols, reads a length header, and packs
//  BPSK (1 b/sym) or QPSK (2 b/sym) symbols MSB-first into BYTES*8-bit words.
//  Words are buffered in a FIFO and emitted on AXI-Stream with tlast; BD_sgn corrects 180-deg ambiguity.
// PARAMETERS
//  BYTES            1   output word width in bytes (W = BYTES*8 bits)
//  MAX_WINDOW_WIDTH 8   width of RX_BD_WINDOW
//  LEN_WIDTH        8   header length field width (payload length in words)
//  FIFO_DEPTH       16  output FIFO depth in words, power of two >= 2
// PORTS
//  clk          in  1   system clock
//  rst          in  1   asynchronous, active-low reset
//  RX_BD_WINDOW in  MWW symbols skipped after BD_flag before header
//  is_bpsk_in   in  1   1 = BPSK payload, 0 = QPSK; sampled at BD_flag
//  PD_flag      in  1   preamble detected (1-cycle pulse)
//  BD_flag      in  1   Barker detected (1-cycle pulse)
//  BD_sgn       in  1   Barker correlation sign; 1 = invert all bits; sampled at BD_flag
//  sym_valid    in  1   in_QPSK valid this cycle
//  in_QPSK      in  2   symbol {I,Q}; BPSK uses in_QPSK[1]
//  data_tdata   out W   AXIS payload word
//  data_tvalid  out 1   AXIS valid
//  data_tready  in  1   AXIS ready
//  data_tlast   out 1   last word of packet
//  data_tuser   out 1   packet mode (1 = BPSK), constant across a packet
//  is_bpsk      out 1   latched mode of current packet
//  disassert_BD out 1   1-cycle pulse: packet finished or aborted, clear Barker detector
//  disassert_PD out 1   same cycle as disassert_BD
//  overflow     out 1   sticky: word dropped on full FIFO; cleared only at reset
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; FIFO empty; counters 0.
//  States: IDLE -> ARMED on PD_flag. ARMED -> SKIP on BD_flag (latch is_bpsk_in, BD_sgn; load
//   skip counter = RX_BD_WINDOW). SKIP: decrement per sym_valid; at 0 -> HEADER (window 0 -> HEADER next cycle).
//  HEADER: collect LEN_WIDTH bits MSB-first via the same bit unpacker; LEN = 0 -> ABORT; else -> PAYLOAD.
//  PAYLOAD: shift bits into W-bit register; on word completion push {word, last} to FIFO;
//   after LEN words -> DONE. DONE/ABORT: pulse disassert_BD/PD one cycle, -> IDLE.
//  Bit unpacking: QPSK pushes in_QPSK[1] then in_QPSK[0]; BPSK pushes in_QPSK[1]; each bit XOR BD_sgn.
//   QPSK with odd LEN_WIDTH: surplus bit of the last header symbol is first payload bit.
//  PD_flag or BD_flag while in SKIP/HEADER/PAYLOAD: ignored (packet in progress wins).
//  Word counter is LEN_WIDTH bits, no wrap: max packet = 2^LEN_WIDTH-1 words.
//  FIFO: push and pop in same cycle allowed when full or empty-with-push (no bypass: 1-cycle min latency
//   from word completion to tvalid). Full on push -> word dropped, overflow set; a dropped last
//   word loses tlast (sink must time out).
//  AXIS: tdata/tlast/tuser stable while tvalid & !tready; tvalid never drops without handshake.
//  Reset mid-packet: FSM, FIFO and partial word cleared immediately; no tlast emitted.
// CONFIGURATION
//  DEPACK_STATS_EN defined: adds outputs pkt_count[15:0] (+1 per DONE) and drop_count[15:0]
//   (+1 per dropped word), both saturating at 16'hFFFF, reset 0.
//  Not defined: ports absent, no counter logic.
// TESTING
//  QPSK, window 3, LEN=2, BYTES=1, payload 0xA5,0x3C, tready=1 -> 2 beats, tlast on 0x3C, disassert pulse x1.
//  BPSK, BD_sgn=1, LEN=1, sent bits of 0x5A inverted -> output 0x5A, tuser=1.
//  Header LEN=0 -> no tvalid, disassert_BD/PD pulse, FSM back in IDLE, accepts next PD_flag.
//  tready=0 throughout, LEN=20, FIFO_DEPTH=16 -> 16 words held, overflow=1, drop_count=4 (STATS_EN).
//  tready toggling 1010 on LEN=5 -> all 5 words in order, tdata stable across stalls.
//  rst low mid-PAYLOAD -> tvalid=0 next edge, FIFO empty; new packet after release decodes correctly.

Source files
------------

// File: rtl/depacketizer_axis_stream.sv
// depacketizer_axis_stream
// Receive-side framer: preamble/Barker sequencing, post-Barker symbol skip, length
// header, BPSK/QPSK bit unpacking into BYTES*8-bit words, output FIFO and AXI-Stream.
// Build macro DEPACK_STATS_EN adds the pkt_count / drop_count statistics outputs.
module depacketizer_axis_stream #(
    parameter int BYTES            = 1,
    parameter int MAX_WINDOW_WIDTH = 8,
    parameter int LEN_WIDTH        = 8,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_WINDOW_WIDTH-1:0] RX_BD_WINDOW,
    input  logic                        is_bpsk_in,
    input  logic                        PD_flag,
    input  logic                        BD_flag,
    input  logic                        BD_sgn,
    input  logic                        sym_valid,
    input  logic [1:0]                  in_QPSK,
    output logic [BYTES*8-1:0]          data_tdata,
    output logic                        data_tvalid,
    input  logic                        data_tready,
    output logic                        data_tlast,
    output logic                        data_tuser,
    output logic                        is_bpsk,
    output logic                        disassert_BD,
    output logic                        disassert_PD,
    output logic                        overflow
`ifdef DEPACK_STATS_EN
    ,
    output logic [15:0]                 pkt_count,
    output logic [15:0]                 drop_count
`endif
);

    localparam int W  = BYTES * 8;
    localparam int HB = $clog2(LEN_WIDTH + 1);
    localparam int WB = $clog2(W + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = W + 2;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SKIP,
        HEADER,
        PAYLOAD,
        DONE,
        ABORT
    } state_t;

    state_t state, state_n;

    // packet context latched at Barker detection
    logic                        mode;
    logic                        sgn;
    logic [MAX_WINDOW_WIDTH-1:0] skip_cnt;

    // unpacker state
    logic [HB-1:0]        hdr_bits, n_hdr_bits;
    logic [LEN_WIDTH-1:0] hdr_reg,  n_hdr_reg;
    logic [LEN_WIDTH-1:0] len,      n_len;
    logic [W-1:0]         word_reg, n_word_reg;
    logic [WB-1:0]        word_bits, n_word_bits;
    logic [LEN_WIDTH-1:0] words_done, n_words_done;

    // unpacker events for this cycle
    logic         in_hdr;
    logic         bit_v;
    logic         hdr_end;
    logic         len_zero;
    logic         pkt_end;
    logic         push;
    logic         push_last;
    logic [W-1:0] push_word;
    logic         disassert;

    // FIFO
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, accept, drop;
    logic [FW-1:0] head;

    // Bit unpacker: walks the (up to two) bits of this symbol in order, feeding the
    // header shifter until LEN_WIDTH bits are in, then the payload word shifter.
    always_comb begin
        n_hdr_bits   = hdr_bits;
        n_hdr_reg    = hdr_reg;
        n_len        = len;
        n_word_reg   = word_reg;
        n_word_bits  = word_bits;
        n_words_done = words_done;
        in_hdr       = (state == HEADER);
        bit_v        = 1'b0;
        hdr_end      = 1'b0;
        len_zero     = 1'b0;
        pkt_end      = 1'b0;
        push         = 1'b0;
        push_last    = 1'b0;
        push_word    = '0;
        if (sym_valid && (state == HEADER || state == PAYLOAD)) begin
            for (int k = 0; k < 2; k++) begin
                if ((k == 0 || !mode) && !len_zero && !pkt_end) begin
                    bit_v = ((k == 0) ? in_QPSK[1] : in_QPSK[0]) ^ sgn;
                    if (in_hdr) begin
                        n_hdr_reg  = (n_hdr_reg << 1) | LEN_WIDTH'(bit_v);
                        n_hdr_bits = n_hdr_bits + HB'(1);
                        if (n_hdr_bits == HB'(LEN_WIDTH)) begin
                            in_hdr   = 1'b0;
                            hdr_end  = 1'b1;
                            n_len    = n_hdr_reg;
                            len_zero = (n_hdr_reg == '0);
                        end
                    end else begin
                        n_word_reg  = (n_word_reg << 1) | W'(bit_v);
                        n_word_bits = n_word_bits + WB'(1);
                        if (n_word_bits == WB'(W)) begin
                            push         = 1'b1;
                            push_word    = n_word_reg;
                            push_last    = (n_words_done == (n_len - LEN_WIDTH'(1)));
                            n_words_done = n_words_done + LEN_WIDTH'(1);
                            n_word_bits  = '0;
                            pkt_end      = push_last;
                        end
                    end
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // FSM next state; DONE/ABORT each last one cycle and drive the detector clear pulse
    always_comb begin
        state_n   = state;
        disassert = 1'b0;
        case (state)
            IDLE:    if (PD_flag) state_n = ARMED;
            ARMED:   if (BD_flag) state_n = SKIP;
            SKIP:    if (skip_cnt == '0 || (sym_valid && skip_cnt == MAX_WINDOW_WIDTH'(1)))
                         state_n = HEADER;
            HEADER:  if (len_zero) state_n = ABORT;
                     else if (hdr_end) state_n = PAYLOAD;
            PAYLOAD: if (pkt_end) state_n = DONE;
            DONE, ABORT: begin
                disassert = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign disassert_BD = disassert;
    assign disassert_PD = disassert;
    assign is_bpsk      = mode;

    // Packet context and unpacker registers; cleared on reset so a new packet never
    // inherits a partial word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode       <= 1'b0;
            sgn        <= 1'b0;
            skip_cnt   <= '0;
            hdr_bits   <= '0;
            hdr_reg    <= '0;
            len        <= '0;
            word_reg   <= '0;
            word_bits  <= '0;
            words_done <= '0;
        end else begin
            case (state)
                ARMED: if (BD_flag) begin
                    mode       <= is_bpsk_in;
                    sgn        <= BD_sgn;
                    skip_cnt   <= RX_BD_WINDOW;
                    hdr_bits   <= '0;
                    hdr_reg    <= '0;
                    len        <= '0;
                    word_reg   <= '0;
                    word_bits  <= '0;
                    words_done <= '0;
                end
                SKIP: if (sym_valid && skip_cnt != '0)
                    skip_cnt <= skip_cnt - MAX_WINDOW_WIDTH'(1);
                HEADER, PAYLOAD: begin
                    hdr_bits   <= n_hdr_bits;
                    hdr_reg    <= n_hdr_reg;
                    len        <= n_len;
                    word_reg   <= n_word_reg;
                    word_bits  <= n_word_bits;
                    words_done <= n_words_done;
                end
                default: ;
            endcase
        end
    end

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = !empty && data_tready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;
    assign head   = mem[rd_ptr[AW-1:0]];

    // FIFO storage {tuser, tlast, word}; written only, never reset
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= {mode, push_last, push_word};
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop)   overflow <= 1'b1;
        end
    end

    // Head of FIFO drives the stream; held at zero while nothing is valid
    assign data_tvalid = !empty;
    assign data_tdata  = empty ? '0   : head[W-1:0];
    assign data_tlast  = empty ? 1'b0 : head[W];
    assign data_tuser  = empty ? 1'b0 : head[W+1];

`ifdef DEPACK_STATS_EN
    // Saturating packet and dropped-word counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (state == DONE && pkt_count != 16'hFFFF)  pkt_count  <= pkt_count + 16'd1;
            if (drop && drop_count != 16'hFFFF)          drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
